// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and branch encodings for the pc sequencer
package pc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HALTED
   } state_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BR,
      SEL_JAL,
      SEL_JALR
   } pc_sel_t;

endpackage

// File: rtl/pc_sequencer_branch_cond_eval.sv
// rtl/pc_sequencer_branch_cond_eval.sv - combinational branch condition from funct3 and ALU flags
module branch_cond_eval
   import pc_seq_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero_flag,
   input  logic       lt_flag,
   input  logic       ltu_flag,
   output logic       cond_true
);

   always_comb begin
      cond_true = 1'b0;
      case (funct3)
         F3_BEQ:  cond_true = zero_flag;
         F3_BNE:  cond_true = !zero_flag;
         F3_BLT:  cond_true = lt_flag;
         F3_BGE:  cond_true = !lt_flag;
         F3_BLTU: cond_true = ltu_flag;
         F3_BGEU: cond_true = !ltu_flag;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch sequencer
// Optional misaligned-target trap enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            imem_req,
   input  logic            imem_ack,
   output logic            instr_valid,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr,
   input  logic            halt,
   input  logic [2:0]      funct3,
   input  logic            zero_flag,
   input  logic            lt_flag,
   input  logic            ltu_flag,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   output logic            branch_taken,
   output logic            halted,
   output logic            misalign_trap,
   output logic [XLEN-1:0] trap_epc
`else
   output logic            branch_taken,
   output logic            halted
`endif
);

   state_t          state, state_nxt;
   pc_sel_t         sel;
   logic            cond_true;
   logic            redirect;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] next_pc;

   branch_cond_eval u_cond (
      .funct3    (funct3),
      .zero_flag (zero_flag),
      .lt_flag   (lt_flag),
      .ltu_flag  (ltu_flag),
      .cond_true (cond_true)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (instr_valid && halt) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req     = (state == FETCH);
      halted       = (state == HALTED);
      instr_valid  = imem_req & imem_ack;
      branch_taken = instr_valid & redirect;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      misalign_trap = instr_valid & redirect & (|target[1:0]);
`endif
   end

   // Halt outranks every control transfer so the stopping instruction stays at pc.
   always_comb begin
      sel = SEL_SEQ;
      if (halt)                     sel = SEL_HOLD;
      else if (jalr)                sel = SEL_JALR;
      else if (jump)                sel = SEL_JAL;
      else if (branch && cond_true) sel = SEL_BR;
   end

   assign redirect = (sel == SEL_BR) || (sel == SEL_JAL) || (sel == SEL_JALR);
   assign pc_plus4 = pc + XLEN'(4);
   assign jalr_sum = rs1_data + imm;

   always_comb begin
      target = pc_plus4;
      case (sel)
         SEL_HOLD:        target = pc;
         SEL_SEQ:         target = pc_plus4;
         SEL_BR, SEL_JAL: target = pc + imm;
         SEL_JALR:        target = jalr_sum & ~XLEN'(1);
         default:         target = pc_plus4;
      endcase
   end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   assign next_pc = (redirect && (|target[1:0])) ? TRAP_VECTOR : target;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                trap_epc <= '0;
      else if (misalign_trap) trap_epc <= pc;
   end
`else
   assign next_pc = redirect ? {target[XLEN-1:2], 2'b00} : target;

   logic unused_trap_vector;
   assign unused_trap_vector = ^TRAP_VECTOR;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              pc <= RESET_VECTOR;
      else if (instr_valid) pc <= next_pc;
   end

endmodule
